// File: rtl/ks_pkg.sv
// Shared types for the Kogge-Stone adder final stage.
// Optional: define KS_SUM_OVF_EN to carry a signed-overflow flag with each result.
package ks_pkg;

  localparam int unsigned KS_WIDTH = 16;

  typedef logic [KS_WIDTH-1:0] ks_word_t;

  // One adder result as stored in the output FIFO.
  typedef struct packed {
    ks_word_t sum;
    logic     cout;
`ifdef KS_SUM_OVF_EN
    logic     ovf;
`endif
  } ks_result_t;

endpackage

// File: rtl/ks_sum_xor.sv
// Combinational sum formation from layer-0 propagate and layer-4 carries.
// Ports:
//   p0    - bitwise propagate a^b
//   g4    - group generate, g4[i] is the carry out of bit i (cin already folded in)
//   cin4  - carry-in forwarded through the prefix layers
//   s_c   - sum
//   co_c  - carry out
//   ovf_c - signed overflow (only when KS_SUM_OVF_EN is defined)
module ks_sum_xor
  import ks_pkg::*;
(
  input  ks_word_t p0,
  input  ks_word_t g4,
  input  logic     cin4,
  output ks_word_t s_c,
`ifdef KS_SUM_OVF_EN
  output logic     ovf_c,
`endif
  output logic     co_c
);

  ks_word_t carry_c;

  // Carry into bit i is the carry out of bit i-1; bit 0 takes the forwarded cin.
  assign carry_c = {g4[KS_WIDTH-2:0], cin4};
  assign s_c     = p0 ^ carry_c;
  assign co_c    = g4[KS_WIDTH-1];

`ifdef KS_SUM_OVF_EN
  // Overflow when carry into the MSB differs from carry out of it.
  assign ovf_c = g4[KS_WIDTH-1] ^ g4[KS_WIDTH-2];
`endif

endmodule

// File: rtl/ks_sum_stage.sv
// Final Kogge-Stone stage: forms sum/cout and queues results in a small
// valid/ready FIFO, counting delivered results.
// Optional: define KS_SUM_OVF_EN to add the per-result ovf output.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   p0, g4, cin4        - propagate, layer-4 carries, forwarded carry-in
//   in_valid, in_ready  - upstream handshake (in_ready is state-derived only)
//   sum, cout, [ovf]    - head-of-FIFO result (holds last popped value when empty)
//   out_valid, out_ready- downstream handshake
//   txn_cnt             - results popped, wrapping
module ks_sum_stage
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p0,
  input  logic [WIDTH-1:0] g4,
  input  logic             cin4,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef KS_SUM_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  ks_result_t       mem [DEPTH];
  ks_result_t       head_q;
  ks_result_t       new_res_c;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [OCC_W-1:0] occ, occ_nxt;
  logic             push_c, pop_c;

  // Sum arithmetic.
  ks_sum_xor u_xor (
    .p0   (p0),
    .g4   (g4),
    .cin4 (cin4),
    .s_c  (new_res_c.sum),
`ifdef KS_SUM_OVF_EN
    .ovf_c(new_res_c.ovf),
`endif
    .co_c (new_res_c.cout)
  );

  // Handshake flags come only from occupancy; a pop never frees space in the same cycle.
  assign in_ready  = !rst && (occ < OCC_W'(DEPTH));
  assign out_valid = (occ != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    occ_nxt    = occ;
    if (push_c) wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    if (pop_c)  rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
    occ_nxt = occ + OCC_W'(push_c) - OCC_W'(pop_c);
  end

  // FIFO storage, pointers, head register and delivery counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      head_q  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      txn_cnt <= '0;
    end else begin
      if (push_c) mem[wr_ptr] <= new_res_c;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      occ    <= occ_nxt;
      if (pop_c) txn_cnt <= txn_cnt + CNT_W'(1);
      // Head register follows the next head entry; it holds when the FIFO drains
      // so the last popped value stays visible.
      if (occ_nxt != '0) begin
        head_q <= (push_c && (wr_ptr == rd_ptr_nxt)) ? new_res_c : mem[rd_ptr_nxt];
      end
    end
  end

  assign sum  = head_q.sum;
  assign cout = head_q.cout;
`ifdef KS_SUM_OVF_EN
  assign ovf  = head_q.ovf;
`endif

endmodule

// File: tb/tb_ks_sum_stage.sv
// Directed bench for ks_sum_stage (DEPTH=2, CNT_W=8).
module tb_ks_sum_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] p0, g4;
  logic        cin4, in_valid, in_ready;
  logic [15:0] sum;
  logic        cout, out_valid, out_ready;
  logic [7:0]  txn_cnt;
`ifdef KS_SUM_OVF_EN
  logic        ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ks_sum_stage #(.WIDTH(16), .DEPTH(2), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .p0       (p0),
    .g4       (g4),
    .cin4     (cin4),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .cout     (cout),
`ifdef KS_SUM_OVF_EN
    .ovf      (ovf),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .txn_cnt  (txn_cnt)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Upstream reference: ripple carries give the layer-4 generate vector.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic c;
    logic [15:0] g;
    c = cin;
    for (int i = 0; i < 16; i++) begin
      g[i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      c = g[i];
    end
    p0   = a ^ b;
    g4   = g;
    cin4 = cin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(16'h0, 16'h0, 1'b0);
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_txn", 32'(txn_cnt), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Table vectors: one push each, checked one cycle later, then popped.
    for (int i = 0; i < 7; i++) begin
      tick();
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      in_valid = 1'b1;
      #1;
      check($sformatf("v%0d_no_same_cycle", i), 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].exp_sum));
      check($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
`ifdef KS_SUM_OVF_EN
      check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
`endif
    end
    tick();
    check("tbl_empty", 32'(out_valid), 32'd0);
    check("tbl_hold_last", 32'(sum), 32'h8000);
    check("tbl_txn", 32'(txn_cnt), 32'd7);

    // Back-pressure, then full with simultaneous pop.
    out_ready = 1'b0;
    drive(16'h0001, 16'h0001, 1'b0); in_valid = 1'b1;
    tick();
    drive(16'h1000, 16'h0F00, 1'b0);
    tick();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    drive(16'hFFFF, 16'hFFFF, 1'b0);
    tick();
    check("bp_held_ready", 32'(in_ready), 32'd0);
    check("bp_head0", 32'(sum), 32'h0002);
    out_ready = 1'b1;
    tick();
    check("fp_head1", 32'(sum), 32'h1F00);
    check("fp_valid", 32'(out_valid), 32'd1);
    check("fp_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("fp_head2", 32'(sum), 32'hFFFE);
    check("fp_cout2", 32'(cout), 32'd1);
    tick();
    check("fp_drained", 32'(out_valid), 32'd0);
    check("fp_txn", 32'(txn_cnt), 32'd10);

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    drive(16'h0003, 16'h0004, 1'b0); in_valid = 1'b1;
    tick();
    drive(16'h0005, 16'h0006, 1'b0);
    tick();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_txn", 32'(txn_cnt), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("no_stale_%0d", k), 32'(out_valid), 32'd0);
    end
    drive(16'h0100, 16'h0023, 1'b0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_sum", 32'(sum), 32'h0123);
    tick();
    check("post_rst_txn", 32'(txn_cnt), 32'd1);

    // Counter wrap: 255 more pops bring the total to 256.
    in_valid = 1'b1;
    for (int k = 0; k < 255; k++) begin
      drive(16'(k), 16'h0000, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8 && out_valid; k++) tick();
    check("wrap_drained", 32'(out_valid), 32'd0);
    check("wrap_last_sum", 32'(sum), 32'd254);
    check("wrap_txn", 32'(txn_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ks_sum_stage.md
Name: ks_sum_stage

Overview:
- Final stage of the 16-bit Kogge-Stone adder, directly downstream of the layer-4 prefix stage.
- Consumes bitwise propagate bits (A^B) and the layer-4 group-generate (carry) vector, and forms SUM/COUT.
- Results are registered into a small valid/ready output FIFO so the adder can be pipelined against a back-pressuring consumer.
- Also keeps a wrap-around count of delivered results.

Parameters:
- WIDTH, 16, adder width; must equal the prefix-tree width (only 16 supported).
- DEPTH, 2, output FIFO entries; legal values 1..4.
- CNT_W, 8, width of TXN_CNT.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- P0  input  WIDTH  bitwise propagate A[i]^B[i] from layer 0.
- G4  input  WIDTH  layer-4 group generate; G4[i] = carry out of bit i, CIN already folded in.
- CIN4  input  1  carry-in forwarded through the prefix layers.
- IN_VALID  input  1  P0/G4/CIN4 valid this cycle.
- IN_READY  output  1  stage can accept a result.
- SUM  output  WIDTH  sum at FIFO head.
- COUT  output  1  carry out at FIFO head.
- OUT_VALID  output  1  head entry valid.
- OUT_READY  input  1  consumer accepts head.
- TXN_CNT  output  CNT_W  number of results popped, modulo 2^CNT_W.

Behaviour:
- Sum arithmetic, combinational on inputs:
  - C[0] = CIN4; C[i] = G4[i-1] for i = 1..15.
  - S[i] = P0[i] ^ C[i].
  - CO = G4[15].
- Push when IN_VALID & IN_READY: write {S, CO} to the tail at the next CLK edge.
- Latency: a result is visible on SUM/COUT with OUT_VALID=1 one cycle after acceptance.
- Pop when OUT_VALID & OUT_READY: advance the head; TXN_CNT increments by 1 and wraps 2^CNT_W-1 -> 0.
- IN_READY = (occupancy < DEPTH). It is registered/state-derived only, with no combinational path from OUT_READY.
  - When full, a same-cycle pop does not enable a push.
- OUT_VALID = (occupancy != 0).
- SUM/COUT always show the head entry and hold stable while OUT_VALID & !OUT_READY.
- Empty FIFO: SUM/COUT show the last popped entry, or 0 after reset.
- Simultaneous push and pop (not full, not empty): occupancy unchanged; head and tail pointers both advance.
- Push into an empty FIFO: OUT_VALID rises the next cycle, never the same cycle.
- Pointers wrap modulo DEPTH.
- Reset, asynchronous and active at any time including mid-transfer:
  - occupancy=0, pointers=0, all entries=0.
  - SUM=0, COUT=0, OUT_VALID=0, TXN_CNT=0.
  - IN_READY=1 while RST is low after release (0 while RST is high).
  - Any in-flight entries are discarded.
- Input ports are not sampled while IN_READY=0.

Optional Feature:
- Macro KS_SUM_OVF_EN.
- Defined:
  - Extra output OVF (1 bit), stored per FIFO entry.
  - OVF = G4[15] ^ G4[14], i.e. signed two's-complement overflow.
  - Reset value 0; presented and held with the head like SUM.
- Undefined: the port is absent, no storage is added, and all other behaviour is identical.

Decomposition:
- Shared package ks_pkg:
  - KS_WIDTH=16.
  - typedef ks_word_t (logic [KS_WIDTH-1:0]).
  - typedef ks_result_t struct {sum, cout[, ovf]}.
- One sub-module: ks_sum_xor, purely combinational (P0, G4, CIN4 -> S, CO[, OVF]).
- ks_sum_stage holds the FIFO, handshake logic and counter.

Test Plan:
- Bench drives the upstream layers from A/B/CIN via a reference model; OUT_READY=1.
  - 0x00FF+0x0001, CIN=0 -> SUM=0x0100, COUT=0, one cycle after push.
  - 0xFFFF+0x0001 -> SUM=0x0000, COUT=1.
  - 0x0000+0x0000, CIN=1 -> SUM=0x0001.
- Back-pressure: OUT_READY=0, push 3 back-to-back values (DEPTH=2).
  - After 2 pushes, IN_READY=0; the third is held upstream.
  - Raise OUT_READY: values pop in order, one per cycle.
  - Third is accepted only after occupancy <2; TXN_CNT=3 at the end.
- Full with simultaneous pop: full and OUT_READY=1 with IN_VALID=1.
  - Pop occurs; no push that cycle.
  - Push happens the next cycle; no data lost or duplicated.
- Reset mid-operation: assert RST asynchronously (between edges) with 2 entries held.
  - OUT_VALID, SUM and TXN_CNT go to 0 immediately.
  - After release, IN_READY=1 and no stale entry ever appears.
- TXN_CNT wrap: 256 pops -> TXN_CNT returns to 0x00.
- With KS_SUM_OVF_EN defined:
  - 0x7FFF+0x0001 -> SUM=0x8000, OVF=1.
  - 0xFFFF+0x0001 -> OVF=0.
